spdif_subframe_assembler: RTL
=============================

// Module: spdif_subframe_assembler
// PURPOSE
// - Stage directly downstream of the biphase-mark decoder. Consumes its serial decoded-bit stream (din/vin) plus channel and frame_counter.
// - Assembles each 28-bit subframe body, after the preamble, into one parallel sample with V/U/C flags and an even-parity check.
// - Collects the channel-status C bits of one channel into a full block image for the control logic.
// PARAMETERS
// SAMPLE_W    24   audio+aux sample width; body = SAMPLE_W + 4 bits (V,U,C,P)
// BLOCK_LEN   192  frames per channel-status block
// CS_CHANNEL  0    channel whose C bits fill cs_block (0 = A/left, 1 = B/right)
// PORTS
// clk            in   1          system clock
// rst_n          in   1          async active-low reset
// din            in   1          decoded data bit (decoder dout)
// vin            in   1          din valid strobe (decoder vout); 1-cycle pulses
// channel        in   1          current subframe channel from decoder
// frame_counter  in   8          current frame index from decoder (0..BLOCK_LEN-1)
// sample         out  SAMPLE_W   assembled sample, bit0 = first received bit
// sample_ch      out  1          channel of sample
// sample_frame   out  8          frame_counter latched with sample
// v_flag,u_bit,c_bit out 1 each  V/U/C bits of the subframe
// parity_err     out  1          even parity over all SAMPLE_W+4 bits failed
// sample_valid   out  1          1-cycle strobe; qualifies all sample_* outputs
// framing_err    out  1          1-cycle strobe; subframe short or over-long
// cs_block       out  BLOCK_LEN  channel-status image, bit k = C of frame k
// cs_valid       out  1          1-cycle strobe; cs_block complete
// BEHAVIOUR
// - Async reset: all outputs 0, bit_cnt 0, shift reg 0, tag {channel,frame_counter} = 9'h1FF.
// - Subframe sync: each cycle, compare tag_q with {channel,frame_counter}. A change marks a new subframe (the decoder updates these in its preamble).
//   - On a change: tag_q <= new value; bit_cnt <= 0; over flag cleared.
//   - If 0 < bit_cnt < SAMPLE_W+4 at the change, framing_err pulses next cycle and the partial body is discarded.
// - Bit capture: on vin with bit_cnt < SAMPLE_W+4, body[bit_cnt] <= din; bit_cnt++. Bits are LSB-first.
// - Commit: the vin that writes bit SAMPLE_W+3 (P) triggers commit. On the next cycle:
//   - sample_valid = 1
//   - sample = body[SAMPLE_W-1:0]
//   - v_flag = body[SAMPLE_W]; u_bit = body[SAMPLE_W+1]; c_bit = body[SAMPLE_W+2]
//   - parity_err = ^body (incl. P)
//   - sample_ch and sample_frame taken from tag_q
//   - Latency: 1 clk after the final vin.
// - Over-long: a vin with bit_cnt == SAMPLE_W+4 is ignored. framing_err pulses once; the over flag suppresses repeats until the next subframe.
// - Simultaneous events: a tag change and a vin in the same cycle: tag change applies first, and that vin is stored as bit 0 of the new subframe.
// - Hold: sample_* outputs hold between strobes. Strobes are single-cycle. There is no backpressure; the consumer must accept every strobe.
// - Channel status: on commit with sample_ch == CS_CHANNEL and parity ok:
//   - cs_shadow[sample_frame] <= c_bit
//   - Frames >= BLOCK_LEN are ignored.
//   - Parity-failed subframes leave the cs bit unchanged.
// - Block complete: if that commit has sample_frame == BLOCK_LEN-1:
//   - the next cycle cs_block <= shadow with the new bit merged, and cs_valid pulses.
//   - cs_block holds until the next completed block.
// - Reset mid-subframe: everything clears. Capture resumes at the next tag change.
// - The first subframe after reset always syncs, because the reset tag 9'h1FF is unreachable.
// TESTING
// 1. Ch A, frame 0, body 24'hA5A5A5, V=0 U=1 C=1, P even (=0) -> sample_valid 1 clk after the 28th vin; sample=24'hA5A5A5, u_bit=1, c_bit=1, parity_err=0.
// 2. Same body, P flipped to 1 -> parity_err=1, sample still 24'hA5A5A5; cs_block bit 0 not written.
// 3. Only 10 bits, then channel 0->1 -> framing_err pulse, no sample_valid; the next 28-bit body on ch B commits with sample_ch=1.
// 4. 30 vins without a tag change -> one sample_valid after bit 28, exactly one framing_err; bits 29-30 are dropped.
// 5. 192 frames on ch A, C = frame[0] -> one cs_valid after frame 191; cs_block = {96{2'b10}}; ch B C bits are ignored.
// 6. Assert rst_n low at bit 15, release, then feed a full subframe -> outputs 0 during reset; the new subframe commits correctly with no framing_err.

Source files
------------

// File: rtl/spdif_subframe_assembler.sv
// S/PDIF subframe assembler: gathers decoded body bits into samples with V/U/C/P
// flags, parity and framing checks, and builds the channel-status block image.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   din, vin             decoded bit and its 1-cycle valid strobe
//   channel              subframe channel from the decoder
//   frame_counter        frame index from the decoder
//   sample, sample_ch    assembled sample (bit0 first received) and its channel
//   sample_frame         frame index latched with the sample
//   v_flag, u_bit, c_bit V/U/C bits of the subframe
//   parity_err           even parity over the whole body failed
//   sample_valid         1-cycle strobe qualifying the sample_* outputs
//   framing_err          1-cycle strobe: subframe short or over-long
//   cs_block, cs_valid   channel-status image and its completion strobe
module spdif_subframe_assembler #(
  parameter int SAMPLE_W   = 24,
  parameter int BLOCK_LEN  = 192,
  parameter int CS_CHANNEL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 vin,
  input  logic                 channel,
  input  logic [7:0]           frame_counter,
  output logic [SAMPLE_W-1:0]  sample,
  output logic                 sample_ch,
  output logic [7:0]           sample_frame,
  output logic                 v_flag,
  output logic                 u_bit,
  output logic                 c_bit,
  output logic                 parity_err,
  output logic                 sample_valid,
  output logic                 framing_err,
  output logic [BLOCK_LEN-1:0] cs_block,
  output logic                 cs_valid
);

  localparam int BODY_W = SAMPLE_W + 4;
  localparam int CNT_W  = $clog2(BODY_W + 1);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BODY_W - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BODY_W);
  localparam logic [8:0]       BLK  = 9'(BLOCK_LEN);
  localparam logic [7:0]       LFR  = 8'(BLOCK_LEN - 1);
  localparam logic             CSCH = 1'(CS_CHANNEL);

  logic [8:0]           tag_q;
  logic [8:0]           tag_d;
  logic                 tag_chg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BODY_W-1:0]    body;
  logic [BODY_W-1:0]    full_body;
  logic                 over_q;
  logic                 commit;
  logic [BLOCK_LEN-1:0] cs_shadow;
  logic [BLOCK_LEN-1:0] cs_next;
  logic                 cs_we;
  logic                 cs_done;

  assign tag_d   = {channel, frame_counter};
  assign tag_chg = (tag_q != tag_d);

  // Body as it will look once the P bit arriving now is stored.
  assign full_body = {din, body[BODY_W-2:0]};

  // A vin coinciding with a tag change is bit 0 of the new subframe,
  // so it can never be the commit bit.
  assign commit = vin && !tag_chg && (bit_cnt == LAST);

  // Channel-status update is driven from the registered sample outputs.
  assign cs_we = sample_valid && (sample_ch == CSCH) && !parity_err &&
                 ({1'b0, sample_frame} < BLK);
  assign cs_done = cs_we && (sample_frame == LFR);

  always_comb begin
    cs_next = cs_shadow;
    if (cs_we) cs_next[sample_frame] = c_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= 9'h1FF;
      bit_cnt      <= '0;
      body         <= '0;
      over_q       <= 1'b0;
      sample       <= '0;
      sample_ch    <= 1'b0;
      sample_frame <= '0;
      v_flag       <= 1'b0;
      u_bit        <= 1'b0;
      c_bit        <= 1'b0;
      parity_err   <= 1'b0;
      sample_valid <= 1'b0;
      framing_err  <= 1'b0;
      cs_shadow    <= '0;
      cs_block     <= '0;
      cs_valid     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      framing_err  <= 1'b0;
      cs_valid     <= 1'b0;

      if (tag_chg) begin
        tag_q  <= tag_d;
        over_q <= 1'b0;
        if (bit_cnt != '0 && bit_cnt < FULL) framing_err <= 1'b1;
        if (vin) begin
          body[0] <= din;
          bit_cnt <= CNT_W'(1);
        end else begin
          bit_cnt <= '0;
        end
      end else if (vin) begin
        if (bit_cnt < FULL) begin
          body[bit_cnt] <= din;
          bit_cnt       <= bit_cnt + 1'b1;
        end else if (!over_q) begin
          framing_err <= 1'b1;
          over_q      <= 1'b1;
        end
      end

      if (commit) begin
        sample_valid <= 1'b1;
        sample       <= full_body[SAMPLE_W-1:0];
        v_flag       <= full_body[SAMPLE_W];
        u_bit        <= full_body[SAMPLE_W+1];
        c_bit        <= full_body[SAMPLE_W+2];
        parity_err   <= ^full_body;
        sample_ch    <= tag_q[8];
        sample_frame <= tag_q[7:0];
      end

      cs_shadow <= cs_next;
      if (cs_done) begin
        cs_block <= cs_next;
        cs_valid <= 1'b1;
      end
    end
  end

endmodule
